btb_update_ctrl: RTL and testbench

- Sequences all writes into the direct-mapped branch target buffer (BTB); the BTB has one write port.
- Buffers branch-resolution updates from EX in a small FIFO and issues them to the BTB write port.
- Defers a write while fetch is looking up the same BTB index; a starvation guard limits how long a write can be deferred.
- Runs an invalidate sweep FSM that clears every BTB entry on request, e.g. fence.i or a context switch.

---
 rtl/btb_update_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// Purpose : single owner of the BTB write port; queues EX branch updates and runs the invalidate sweep.
// Latency : an update accepted into an empty queue is written the next cycle unless fetch reads that index.
// Backpr. : upd_ready drops when the queue is full, during an invalidate request and while not IDLE.
//
// Ports
//   clk_i, rst                       clock (rising edge), asynchronous active-high reset
//   upd_valid_i/upd_ready_o          EX update handshake; upd_pc_i (tag) and upd_target_i captured on transfer
//   fetch_valid_i, fetch_index_i     concurrent fetch lookup; a write to the same index is held off
//   inv_req_i, inv_busy_o, inv_done_o  invalidate-all request, sweep in progress, sweep-finished pulse
//   btb_we_o, btb_idx_o, btb_tag_o, btb_tgt_o, btb_vld_o  BTB write port
module btb_update_ctrl #(
    parameter int PC_W       = 32,
    parameter int IDX_W      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int STALL_MAX  = 3
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             upd_valid_i,
    output logic             upd_ready_o,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic [PC_W-1:0]  upd_target_i,
    input  logic             fetch_valid_i,
    input  logic [IDX_W-1:0] fetch_index_i,
    input  logic             inv_req_i,
    output logic             inv_busy_o,
    output logic             inv_done_o,
    output logic             btb_we_o,
    output logic [IDX_W-1:0] btb_idx_o,
    output logic [PC_W-1:0]  btb_tag_o,
    output logic [PC_W-1:0]  btb_tgt_o,
    output logic             btb_vld_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);
    localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Pending-update queue. Only the PC is stored; the BTB index is
    // re-derived from the PC at the head, so no separate index field.
    logic [PC_W-1:0] pc_mem  [FIFO_DEPTH];
    logic [PC_W-1:0] tgt_mem [FIFO_DEPTH];

    // Pointers carry one extra bit so full and empty are distinguishable.
    logic [PW-1:0]    wr_ptr, rd_ptr, count;
    logic             full, empty;
    logic             push, pop, flush;

    logic [IDX_W-1:0] sweep_cnt, sweep_nxt;
    logic [SW-1:0]    stall_cnt, stall_nxt;

    logic [PC_W-1:0]  head_pc, head_tgt;
    logic [IDX_W-1:0] head_idx;
    logic             conflict;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);

    assign head_pc  = pc_mem[rd_ptr[AW-1:0]];
    assign head_tgt = tgt_mem[rd_ptr[AW-1:0]];
    // Instructions are word aligned, so the index starts above bit 1.
    assign head_idx = head_pc[IDX_W+1:2];
    assign conflict = fetch_valid_i && (fetch_index_i == head_idx);

    assign push     = upd_valid_i && upd_ready_o;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state, counters and write-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        sweep_nxt   = sweep_cnt;
        stall_nxt   = stall_cnt;
        flush       = 1'b0;
        pop         = 1'b0;
        upd_ready_o = 1'b0;
        inv_busy_o  = 1'b0;
        inv_done_o  = 1'b0;
        btb_we_o    = 1'b0;
        btb_idx_o   = '0;
        btb_tag_o   = '0;
        btb_tgt_o   = '0;
        btb_vld_o   = 1'b0;

        case (state)
            IDLE: begin
                // No bypass: a full queue refuses even if it pops now.
                upd_ready_o = !full && !inv_req_i;

                // Yield to fetch, unless the head has already waited
                // STALL_MAX cycles; then the write goes regardless.
                if (!empty && (!conflict || stall_cnt == STALL_LIM)) begin
                    btb_we_o  = 1'b1;
                    btb_idx_o = head_idx;
                    btb_tag_o = head_pc;
                    btb_tgt_o = head_tgt;
                    btb_vld_o = 1'b1;
                    pop       = 1'b1;
                end

                if (inv_req_i) begin
                    // Any write issued this cycle still lands; the rest
                    // of the queue is stale once everything is cleared.
                    state_nxt = SWEEP;
                    flush     = 1'b1;
                    sweep_nxt = '0;
                    stall_nxt = '0;
                end else if (pop || empty) begin
                    stall_nxt = '0;
                end else if (conflict && stall_cnt != STALL_LIM) begin
                    stall_nxt = stall_cnt + 1'b1;
                end
            end

            SWEEP: begin
                // Fetch lookups are not honoured here: entries are being
                // invalidated and any hit would be discarded anyway.
                btb_we_o   = 1'b1;
                btb_idx_o  = sweep_cnt;
                inv_busy_o = 1'b1;
                sweep_nxt  = sweep_cnt + 1'b1;
                stall_nxt  = '0;
                if (sweep_cnt == '1) begin
                    state_nxt = DONE;
                end
            end

            DONE: begin
                inv_done_o = 1'b1;
                state_nxt  = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Queue pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            // upd_ready is low whenever flush is high, so nothing is lost
            // from the write side here.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Queue storage is data only and needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr[AW-1:0]]  <= upd_pc_i;
            tgt_mem[wr_ptr[AW-1:0]] <= upd_target_i;
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Purpose : self-checking bench for btb_update_ctrl (scoreboard against a queue-based reference model).
// Latency : expectations are formed on the falling edge and checked 1 ns later.
// Backpr. : stimulus holds upd_valid until a transfer is seen.
module tb_btb_update_ctrl;

    localparam int PC_W  = 32;
    localparam int IDX_W = 3;
    localparam int DEPTH = 4;
    localparam int SMAX  = 3;
    localparam int NENT  = 1 << IDX_W;

    logic             clk_i = 1'b0;
    logic             rst = 1'b1;
    logic             upd_valid_i = 1'b0;
    logic             upd_ready_o;
    logic [PC_W-1:0]  upd_pc_i = '0;
    logic [PC_W-1:0]  upd_target_i = '0;
    logic             fetch_valid_i = 1'b0;
    logic [IDX_W-1:0] fetch_index_i = '0;
    logic             inv_req_i = 1'b0;
    logic             inv_busy_o, inv_done_o;
    logic             btb_we_o;
    logic [IDX_W-1:0] btb_idx_o;
    logic [PC_W-1:0]  btb_tag_o, btb_tgt_o;
    logic             btb_vld_o;

    btb_update_ctrl #(
        .PC_W(PC_W), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .STALL_MAX(SMAX)
    ) dut (
        .clk_i(clk_i), .rst(rst),
        .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
        .upd_pc_i(upd_pc_i), .upd_target_i(upd_target_i),
        .fetch_valid_i(fetch_valid_i), .fetch_index_i(fetch_index_i),
        .inv_req_i(inv_req_i), .inv_busy_o(inv_busy_o), .inv_done_o(inv_done_o),
        .btb_we_o(btb_we_o), .btb_idx_o(btb_idx_o), .btb_tag_o(btb_tag_o),
        .btb_tgt_o(btb_tgt_o), .btb_vld_o(btb_vld_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [PC_W-1:0] pc; logic [PC_W-1:0] tgt; } upd_t;
    typedef struct { int cyc; logic [IDX_W-1:0] idx; logic [PC_W-1:0] tag; logic [PC_W-1:0] tgt; logic vld; } wr_t;
    typedef struct { int cyc; logic ready; logic busy; logic done; } fl_t;

    upd_t pend[$];     // updates waiting for the write port, oldest first
    wr_t  exp_wr[$];   // writes the BTB must see, with the cycle they occur in
    fl_t  exp_fl[$];   // per-cycle handshake/status expectations
    int   m_mode  = 0; // 0 idle, 1 sweeping, 2 done
    int   m_sweep = 0; // next entry to clear
    int   m_wait  = 0; // consecutive cycles the head has been held off

    always @(negedge clk_i) begin
        fl_t  f;
        wr_t  w;
        upd_t u;
        logic [IDX_W-1:0] hidx;
        bit   wr, conf, acc;
        f.cyc = cyc; f.ready = 1'b0; f.busy = 1'b0; f.done = 1'b0;
        wr = 0; conf = 0; acc = 0;
        if (rst) begin
            pend.delete();
            m_mode = 0; m_sweep = 0; m_wait = 0;
            f.ready = !inv_req_i;
        end else if (m_mode == 0) begin
            f.ready = (pend.size() < DEPTH) && !inv_req_i;
            acc = upd_valid_i && f.ready;
            if (pend.size() > 0) begin
                hidx = pend[0].pc[IDX_W+1:2];
                conf = fetch_valid_i && (fetch_index_i == hidx);
                wr   = !conf || (m_wait == SMAX);
                if (wr) begin
                    w.cyc = cyc; w.idx = hidx; w.tag = pend[0].pc; w.tgt = pend[0].tgt; w.vld = 1'b1;
                    exp_wr.push_back(w);
                end
            end
            if (inv_req_i) begin
                pend.delete();
                m_wait = 0; m_mode = 1; m_sweep = 0;
            end else begin
                if (wr) begin
                    void'(pend.pop_front());
                    m_wait = 0;
                end else if (pend.size() == 0) begin
                    m_wait = 0;
                end else if (conf && m_wait < SMAX) begin
                    m_wait++;
                end
                if (acc) begin
                    u.pc = upd_pc_i; u.tgt = upd_target_i;
                    pend.push_back(u);
                end
            end
        end else if (m_mode == 1) begin
            f.busy = 1'b1;
            w.cyc = cyc; w.idx = IDX_W'(m_sweep); w.tag = '0; w.tgt = '0; w.vld = 1'b0;
            exp_wr.push_back(w);
            m_sweep++;
            if (m_sweep == NENT) m_mode = 2;
        end else begin
            f.done = 1'b1;
            m_mode = 0;
        end
        exp_fl.push_back(f);
    end

    // ---------------- monitor ----------------
    always @(negedge clk_i) begin
        fl_t f;
        wr_t w;
        #1;
        if (exp_fl.size() > 0) begin
            f = exp_fl.pop_front();
            check("upd_ready", 64'(upd_ready_o), 64'(f.ready));
            check("inv_busy",  64'(inv_busy_o),  64'(f.busy));
            check("inv_done",  64'(inv_done_o),  64'(f.done));
        end
        if (rst) begin
            check("rst_wr_fields", {btb_tag_o, btb_tgt_o}, 64'd0);
            check("rst_idx_vld", 64'({btb_idx_o, btb_vld_o}), 64'd0);
        end
        if (btb_we_o) begin
            if (exp_wr.size() == 0) begin
                check("spurious_we", 64'(btb_we_o), 64'd0);
            end else begin
                w = exp_wr.pop_front();
                check("wr_cycle", 64'(cyc), 64'(w.cyc));
                check("wr_idx", 64'(btb_idx_o), 64'(w.idx));
                check("wr_tag", 64'(btb_tag_o), 64'(w.tag));
                check("wr_tgt", 64'(btb_tgt_o), 64'(w.tgt));
                check("wr_vld", 64'(btb_vld_o), 64'(w.vld));
            end
        end else if (exp_wr.size() > 0 && exp_wr[0].cyc <= cyc) begin
            check("missed_we", 64'(btb_we_o), 64'd1);
            void'(exp_wr.pop_front());
        end
    end

    // ---------------- fetch driver ----------------
    // 0 quiet, 1 track queue head, 2 alternate index 2/5 (starting at 2), 3 random
    int fmode = 0;
    always @(posedge clk_i) begin
        int  prev;
        bit  alt;
        #2;
        if (fmode == 2 && prev != 2) alt = 0;
        case (fmode)
            1: begin
                fetch_valid_i = 1'b1;
                fetch_index_i = (pend.size() > 0) ? pend[0].pc[IDX_W+1:2] : '0;
            end
            2: begin
                fetch_valid_i = 1'b1;
                fetch_index_i = alt ? 3'd5 : 3'd2;
                alt = !alt;
            end
            3: begin
                fetch_valid_i = 1'($urandom_range(0, 1));
                fetch_index_i = IDX_W'($urandom_range(0, NENT - 1));
            end
            default: begin
                fetch_valid_i = 1'b0;
                fetch_index_i = '0;
            end
        endcase
        prev = fmode;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt);
        bit got;
        int n;
        got = 0;
        n = 0;
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_target_i = tgt;
        while (!got && n < 100) begin
            @(negedge clk_i);
            got = upd_ready_o;
            step();
            n++;
        end
        if (!got) check("send_timeout", 64'(got), 64'd1);
        upd_valid_i = 1'b0;
    endtask

    initial begin
        #1;
        check("reset_ready", 64'(upd_ready_o), 64'd1);
        check("reset_we", 64'({btb_we_o, inv_busy_o, inv_done_o}), 64'd0);
        repeat (3) step();
        rst = 1'b0;
        step();

        // single update, no fetch traffic
        send(32'h8000_0010, 32'h8000_0100);
        repeat (4) step();

        // five back-to-back updates with fetch always hitting the head
        fmode = 1;
        for (int i = 0; i < 5; i++) send(32'h0000_1000 + 32'(i * 4), 32'hA000_0000 + 32'(i));
        repeat (30) step();
        fmode = 0;
        repeat (2) step();

        // head at index 2, fetch alternates 2 / 5
        fmode = 2;
        send(32'h4000_0008, 32'h4000_0800);
        repeat (6) step();
        fmode = 0;
        repeat (2) step();

        // randomized traffic
        fmode = 3;
        for (int i = 0; i < 400; i++) begin
            upd_valid_i  = 1'($urandom_range(0, 1));
            upd_pc_i     = $urandom & 32'hFFFF_FFFC;
            upd_target_i = $urandom;
            inv_req_i    = ($urandom_range(0, 39) == 0);
            step();
        end
        upd_valid_i = 1'b0;
        inv_req_i   = 1'b0;
        fmode = 0;
        repeat (15) step();

        // invalidate with updates still pending
        fmode = 1;
        for (int i = 0; i < 4; i++) send(32'h0000_2000 + 32'(i * 4), 32'hB000_0000 + 32'(i));
        inv_req_i = 1'b1;
        step();
        inv_req_i = 1'b0;
        fmode = 0;
        repeat (12) step();

        // update and invalidate together: update must be refused
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h0000_3004;
        upd_target_i = 32'hC000_0000;
        inv_req_i    = 1'b1;
        step();
        upd_valid_i = 1'b0;
        inv_req_i   = 1'b0;
        repeat (12) step();

        // reset in the middle of a sweep
        inv_req_i = 1'b1;
        step();
        inv_req_i = 1'b0;
        repeat (3) step();
        #1;
        rst = 1'b1;
        #1;
        check("midsweep_rst_out", 64'({btb_we_o, inv_busy_o, inv_done_o, btb_vld_o}), 64'd0);
        check("midsweep_rst_idx", 64'(btb_idx_o), 64'd0);
        check("midsweep_rst_ready", 64'(upd_ready_o), 64'd1);
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        inv_req_i = 1'b1;
        step();
        inv_req_i = 1'b0;
        repeat (14) step();

        check("leftover_writes", 64'(exp_wr.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
